// File: rtl/spi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_pkg : shared constants and state type for the SPI frame link
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int DEFAULT_FRAME_BITS = 336;
  localparam int FRAME_BYTES        = DEFAULT_FRAME_BITS / 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SCK_HIGH = 3'd2,
    ST_SCK_LOW  = 3'd3,
    ST_TRAIL    = 3'd4,
    ST_GAP      = 3'd5
  } spi_tx_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_half_tick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_half_tick : reloadable down-counter, one-cycle tick every HALF_PERIOD
//                 enabled cycles; clear reloads it to a full half-period.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module spi_half_tick #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int                c_cnt_w  = $clog2(HALF_PERIOD + 1);
  localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(HALF_PERIOD);

  logic [c_cnt_w-1:0] r_count;

  assign tick = en && (r_count == c_cnt_w'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= c_reload;
    end else if (en) begin
      r_count <= tick ? c_reload : r_count - c_cnt_w'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_frame_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_frame_tx : SPI mode-0 master, shifts one FRAME_BITS frame MSB-first
//                framed by active-low cs, then enforces a cs-high gap.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module spi_frame_tx
  import spi_pkg::*;
#(
  parameter int FRAME_BITS  = DEFAULT_FRAME_BITS,
  parameter int HALF_PERIOD = 4,
  parameter int CS_GAP      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FRAME_BITS-1:0] data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  sck,
  output logic                  sdo,
  output logic                  cs
);

  localparam int c_bits_w = $clog2(FRAME_BITS + 1);
  localparam int c_gap_w  = $clog2(CS_GAP + 1);

  spi_tx_state_t         r_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [c_bits_w-1:0]   r_bits_left;
  logic [c_gap_w-1:0]    r_gap_left;
  logic                  w_accept;
  logic                  w_tick_en;
  logic                  w_tick;

  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_tick_en = (r_state == ST_SETUP) || (r_state == ST_SCK_HIGH) ||
                     (r_state == ST_SCK_LOW) || (r_state == ST_TRAIL);

  // sdo is the shift register MSB; clearing the register on entry to GAP idles it low
  assign sdo = r_shift[FRAME_BITS-1];

  spi_half_tick #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_half_tick (
    .clk   (clk),
    .reset (reset),
    .clear (w_accept),
    .en    (w_tick_en),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bits_left <= '0;
      r_gap_left  <= '0;
      cs          <= 1'b1;
      sck         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shift     <= data;
            r_bits_left <= c_bits_w'(FRAME_BITS);
            cs          <= 1'b0;
            busy        <= 1'b1;
            r_state     <= ST_SETUP;
          end
        end
        ST_SETUP, ST_SCK_LOW: begin
          if (w_tick) begin
            sck     <= 1'b1;
            r_state <= ST_SCK_HIGH;
          end
        end
        ST_SCK_HIGH: begin
          if (w_tick) begin
            sck         <= 1'b0;
            r_bits_left <= r_bits_left - c_bits_w'(1);
            if (r_bits_left == c_bits_w'(1)) begin
              r_state <= ST_TRAIL;
            end else begin
              r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
              r_state <= ST_SCK_LOW;
            end
          end
        end
        ST_TRAIL: begin
          if (w_tick) begin
            cs         <= 1'b1;
            r_shift    <= '0;
            r_gap_left <= c_gap_w'(CS_GAP);
            r_state    <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_gap_left == c_gap_w'(1)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_gap_left <= r_gap_left - c_gap_w'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_frame_tx : randomized self-checking bench with a cycle-level
//                   timing model and a mode-0 receiver model.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_spi_frame_tx;

  localparam int F       = 8;
  localparam int HP      = 2;
  localparam int G       = 2;
  localparam int CS_LAST = HP * (2 * F + 1);
  localparam int DONE_AT = CS_LAST + G + 1;

  localparam int FB      = 336;
  localparam int DONE_B  = 4 * (2 * FB + 1) + 4 + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [F-1:0]  data;
  logic          busy, done, sck, sdo, cs;

  logic          start_b;
  logic [FB-1:0] data_b;
  logic          busy_b, done_b, sck_b, sdo_b, cs_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_frame_tx #(.FRAME_BITS(F), .HALF_PERIOD(HP), .CS_GAP(G)) dut (
    .clk(clk), .reset(reset), .data(data), .start(start),
    .busy(busy), .done(done), .sck(sck), .sdo(sdo), .cs(cs)
  );

  spi_frame_tx dut_big (
    .clk(clk), .reset(reset), .data(data_b), .start(start_b),
    .busy(busy_b), .done(done_b), .sck(sck_b), .sdo(sdo_b), .cs(cs_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: plain frame, 1: stray start mid-frame, 2: data churn, 3: start held (two frames)
  task automatic send(input int mode, input logic [F-1:0] d, input logic [F-1:0] alt);
    logic exp_bits[$];
    logic cap[$];
    int   cs_falls[$];
    int   cs_rises[$];
    int   nf, ncyc, a, rises, glitch, bad_busy, bad_cs, bad_done, nerr, gap;
    logic p_sck, p_sdo, p_cs, e_busy, e_cs, e_done;
    nf = (mode == 3) ? 2 : 1;
    ncyc = nf * DONE_AT + 3;
    rises = 0; glitch = 0; bad_busy = 0; bad_cs = 0; bad_done = 0; nerr = 0;
    for (int i = F - 1; i >= 0; i--) exp_bits.push_back(d[i]);
    if (mode == 3) for (int i = F - 1; i >= 0; i--) exp_bits.push_back(alt[i]);

    @(negedge clk);
    data  = d;
    start = 1'b1;
    p_sck = sck; p_sdo = sdo; p_cs = cs;
    for (int r = 1; r <= ncyc; r++) begin
      @(negedge clk);
      if (r == 1 && mode != 3) start = 1'b0;
      if (r == 1 && mode == 3) data = alt;
      if (r == DONE_AT + 1 && mode == 3) start = 1'b0;
      if (r == 10 && mode == 1) begin start = 1'b1; data = alt; end
      if (r == 11 && mode == 1) start = 1'b0;
      if (mode == 2) data = F'($urandom);

      e_busy = 1'b0; e_cs = 1'b1; e_done = 1'b0;
      for (int k = 0; k < nf; k++) begin
        a = k * DONE_AT;
        if (r > a && r < a + DONE_AT) e_busy = 1'b1;
        if (r > a && r <= a + CS_LAST) e_cs = 1'b0;
        if (r == a + DONE_AT) e_done = 1'b1;
      end
      if (busy !== e_busy) bad_busy++;
      if (cs !== e_cs || (cs === 1'b1 && sck !== 1'b0)) bad_cs++;
      if (done !== e_done) bad_done++;
      if (p_cs === 1'b1 && cs === 1'b0) cs_falls.push_back(r);
      if (p_cs === 1'b0 && cs === 1'b1) cs_rises.push_back(r);
      if (p_sck === 1'b0 && sck === 1'b1) begin
        rises++;
        cap.push_back(sdo);
        if (sdo !== p_sdo) glitch++;
      end
      if (p_sck === 1'b1 && sck === 1'b1 && sdo !== p_sdo) glitch++;
      p_sck = sck; p_sdo = sdo; p_cs = cs;
    end
    start = 1'b0;

    for (int i = 0; i < exp_bits.size(); i++)
      if (i >= cap.size() || cap[i] !== exp_bits[i]) nerr++;
    check($sformatf("m%0d_rises", mode), rises, F * nf);
    check($sformatf("m%0d_bit_errors", mode), nerr, 0);
    check($sformatf("m%0d_sdo_unstable", mode), glitch, 0);
    check($sformatf("m%0d_busy_cycles_wrong", mode), bad_busy, 0);
    check($sformatf("m%0d_cs_cycles_wrong", mode), bad_cs, 0);
    check($sformatf("m%0d_done_cycles_wrong", mode), bad_done, 0);
    if (mode == 3) begin
      gap = (cs_falls.size() > 1 && cs_rises.size() > 0) ? cs_falls[1] - (cs_rises[0] - 1) : -1;
      check("b2b_cs_gap", gap, G + 2);
    end
  endtask

  initial begin
    int   nd, nerr, idx, done_r;
    logic p;
    reset = 1'b1; start = 1'b0; data = '0; start_b = 1'b0; data_b = '0;
    repeat (3) @(negedge clk);
    check("rst_cs", cs, 1);
    check("rst_sck", sck, 0);
    check("rst_sdo", sdo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_big_cs", cs_b, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    send(0, 8'hA5, 8'h00);
    for (int i = 0; i < 4; i++) send(0, F'($urandom), 8'h00);
    data = F'($urandom);
    send(1, data, ~data);
    send(2, 8'hFF, 8'h00);
    send(2, F'($urandom), 8'h00);
    send(3, 8'h3C, 8'hC3);

    // asynchronous abort at cycle 15 of a frame
    @(negedge clk);
    data = F'($urandom); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_cs", cs, 1);
    check("abort_sck", sck, 0);
    check("abort_busy", busy, 0);
    nd = 0;
    for (int r = 0; r < DONE_AT + 5; r++) begin
      @(negedge clk);
      if (r == 2) reset = 1'b0;
      if (done === 1'b1) nd++;
    end
    check("abort_no_done", nd, 0);
    send(0, F'($urandom), 8'h00);

    // default-sized frame into a mode-0 receiver model
    for (int k = 0; k < FB / 8; k++) data_b[FB - 1 - 8 * k -: 8] = 8'(k);
    @(negedge clk);
    start_b = 1'b1;
    p = sck_b; nerr = 0; idx = 0; done_r = -1;
    for (int r = 1; r <= DONE_B + 5; r++) begin
      @(negedge clk);
      if (r == 1) start_b = 1'b0;
      if (p === 1'b0 && sck_b === 1'b1) begin
        if (idx < FB && sdo_b !== data_b[FB - 1 - idx]) nerr++;
        idx++;
      end
      if (done_b === 1'b1 && done_r < 0) done_r = r;
      p = sck_b;
    end
    check("big_bit_errors", nerr, 0);
    check("big_rises", idx, FB);
    check("big_done_cycle", done_r, DONE_B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
